// File: rtl/reel_spin_ctrl.sv
// Reel scroll controller: per-frame accelerate / cruise / decelerate / seek-to-symbol motion for one reel.
// Optional feature: define REEL_AUTOSTOP_EN to stop automatically after cruise_frames frames in CRUISE.
module reel_spin_ctrl #(
    parameter int SYM_H   = 32,
    parameter int NUM_SYM = 8,
    parameter int TICK_Y  = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        cs,
    input  logic        write,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [10:0] y0,
    output logic        spinning,
    output logic        done
);
    localparam int STRIP_H = SYM_H * NUM_SYM;
    localparam int SYM_W   = $clog2(SYM_H);
    localparam int TGT_W   = $clog2(NUM_SYM);
    localparam int POS_W   = SYM_W + TGT_W;
    localparam int SPD_W   = SYM_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEL  = 3'd1,
        CRUISE = 3'd2,
        DECEL  = 3'd3,
        SEEK   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [POS_W-1:0]   pos_reg, pos_next;
    logic [SPD_W-1:0]   speed_reg, speed_next;
    logic [SPD_W-1:0]   max_speed_reg, max_speed_next;
    logic [7:0]         frame_cnt_reg, frame_cnt_next;
    logic               stop_pending_reg, stop_pending_next;
    logic               done_sticky_reg, done_sticky_next;
    logic               done_reg, done_next;
    logic [TGT_W-1:0]   target_reg, target_next;
    logic               match_prev_reg;
`ifdef REEL_AUTOSTOP_EN
    logic [7:0]         cruise_frames_reg, cruise_frames_next;
`endif

    // Frame tick: first cycle of the (x==0, y==TICK_Y) match, so a held coordinate fires only once.
    logic match, tick;
    assign match = (x == 11'd0) && (y == 11'(TICK_Y));
    assign tick  = match && !match_prev_reg;

    logic wr_en;
    assign wr_en = cs & write;

    logic [SPD_W-1:0] step;
    logic [POS_W:0]   pos_sum;
    logic [POS_W-1:0] pos_adv;
    assign step    = (state_reg == SEEK) ? SPD_W'(1) : speed_reg;
    assign pos_sum = {1'b0, pos_reg} + (POS_W+1)'(step);
    assign pos_adv = (pos_sum >= (POS_W+1)'(STRIP_H)) ? POS_W'(pos_sum - (POS_W+1)'(STRIP_H))
                                                     : pos_sum[POS_W-1:0];

    // Speed ramps clamp to max_speed so a live max_speed write below the current speed cannot overshoot.
    logic [SPD_W-1:0] speed_up, speed_down;
    logic [7:0]       frame_cnt_inc;
    logic             seek_hit;
    logic             auto_stop;
    assign speed_up      = (speed_reg >= max_speed_reg) ? max_speed_reg : speed_reg + SPD_W'(1);
    assign speed_down    = (speed_reg > SPD_W'(1)) ? speed_reg - SPD_W'(1) : SPD_W'(1);
    assign frame_cnt_inc = (frame_cnt_reg == 8'hFF) ? 8'hFF : frame_cnt_reg + 8'd1;
    assign seek_hit      = (pos_adv == {target_reg, {SYM_W{1'b0}}});

`ifdef REEL_AUTOSTOP_EN
    assign auto_stop = (frame_cnt_inc >= cruise_frames_reg);
`else
    assign auto_stop = 1'b0;
`endif

    logic [5:0]       max_field;
    logic [SPD_W-1:0] max_clamped;
    assign max_field = wr_data[5:0];
    always_comb begin
        if (max_field == 6'd0)
            max_clamped = SPD_W'(1);
        else if ({26'd0, max_field} > 32'(SYM_H))
            max_clamped = SPD_W'(SYM_H);
        else
            max_clamped = SPD_W'(max_field);
    end

    logic unused_wr;
    assign unused_wr = ^wr_data[31:6];

    always_comb begin
        state_next        = state_reg;
        pos_next          = pos_reg;
        speed_next        = speed_reg;
        max_speed_next    = max_speed_reg;
        frame_cnt_next    = frame_cnt_reg;
        stop_pending_next = stop_pending_reg;
        done_sticky_next  = done_sticky_reg;
        done_next         = 1'b0;
        target_next       = target_reg;
`ifdef REEL_AUTOSTOP_EN
        cruise_frames_next = cruise_frames_reg;
`endif
        // Tick is evaluated against the pre-write state; register writes below override it.
        if (tick) begin
            case (state_reg)
                ACCEL: begin
                    pos_next   = pos_adv;
                    speed_next = speed_up;
                    if (speed_up >= max_speed_reg) begin
                        state_next     = CRUISE;
                        frame_cnt_next = 8'd0;
                    end
                end
                CRUISE: begin
                    pos_next       = pos_adv;
                    frame_cnt_next = frame_cnt_inc;
                    if (stop_pending_reg || auto_stop) begin
                        state_next        = DECEL;
                        stop_pending_next = 1'b0;
                    end
                end
                DECEL: begin
                    pos_next   = pos_adv;
                    speed_next = speed_down;
                    if (speed_down == SPD_W'(1))
                        state_next = SEEK;
                end
                SEEK: begin
                    pos_next = pos_adv;
                    if (seek_hit) begin
                        state_next       = IDLE;
                        speed_next       = '0;
                        done_next        = 1'b1;
                        done_sticky_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (wr_en) begin
            case (addr)
                2'd0: begin
                    if (wr_data[0] && state_reg == IDLE) begin
                        state_next        = ACCEL;
                        speed_next        = SPD_W'(1);
                        done_sticky_next  = 1'b0;
                        stop_pending_next = 1'b0;
                    end
                    if (wr_data[1] && (state_reg == ACCEL || state_reg == CRUISE))
                        stop_pending_next = 1'b1;
                end
                2'd1: target_next    = wr_data[TGT_W-1:0];
                2'd2: max_speed_next = max_clamped;
                2'd3: begin
`ifdef REEL_AUTOSTOP_EN
                    cruise_frames_next = wr_data[7:0];
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            pos_reg          <= '0;
            speed_reg        <= '0;
            max_speed_reg    <= SPD_W'(8);
            frame_cnt_reg    <= 8'd0;
            stop_pending_reg <= 1'b0;
            done_sticky_reg  <= 1'b0;
            done_reg         <= 1'b0;
            target_reg       <= '0;
            match_prev_reg   <= 1'b0;
`ifdef REEL_AUTOSTOP_EN
            cruise_frames_reg <= 8'd60;
`endif
        end else begin
            state_reg        <= state_next;
            pos_reg          <= pos_next;
            speed_reg        <= speed_next;
            max_speed_reg    <= max_speed_next;
            frame_cnt_reg    <= frame_cnt_next;
            stop_pending_reg <= stop_pending_next;
            done_sticky_reg  <= done_sticky_next;
            done_reg         <= done_next;
            target_reg       <= target_next;
            match_prev_reg   <= match;
`ifdef REEL_AUTOSTOP_EN
            cruise_frames_reg <= cruise_frames_next;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0: rd_data = {28'd0, done_sticky_reg, state_reg};
            2'd1: rd_data = 32'(pos_reg);
            2'd2: rd_data = 32'({speed_reg, max_speed_reg});
            2'd3: begin
`ifdef REEL_AUTOSTOP_EN
                rd_data = 32'(cruise_frames_reg);
`endif
            end
            default: ;
        endcase
    end

    assign y0       = 11'(pos_reg);
    assign spinning = (state_reg != IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Scoreboard bench for reel_spin_ctrl: expected {done, y0} per frame tick is queued by the stimulus
// and popped by a monitor whenever y0 moves or done pulses; register reads are checked inline.
`timescale 1ns/1ps
module tb_reel_spin_ctrl;
    localparam int TICK_Y = 480;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic        cs = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic [10:0] y0;
    logic        spinning;
    logic        done;

    always #5 clk = ~clk;

    reel_spin_ctrl #(.SYM_H(32), .NUM_SYM(8), .TICK_Y(TICK_Y)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .y0(y0),
        .spinning(spinning), .done(done)
    );

    int          tests = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    int          exp_pos = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else
            $display("[TB] ok %s = %0d", name, act);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk); cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk); cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [1:0] a, input logic [31:0] req);
        @(negedge clk); addr = a;
        #1 check(name, rd_data, req);
    endtask

    task automatic do_tick();
        @(negedge clk); x = 11'd0; y = 11'(TICK_Y);
        @(negedge clk); x = 11'd7; y = 11'd100;
    endtask

    // Queue the position the reel must show after a tick moving it by spd, then fire the tick.
    task automatic tick_expect(input int spd, input bit last);
        exp_pos = (exp_pos + spd) % 256;
        exp_q.push_back({last, 11'(exp_pos)});
        do_tick();
    endtask

    initial begin : monitor
        logic [10:0] prev_y0;
        logic [11:0] e;
        prev_y0 = '0;
        forever begin
            @(negedge clk);
            if (!reset)
                prev_y0 = y0;
            else if (y0 !== prev_y0 || done !== 1'b0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL y0_stream: unexpected output done=%0d y0=%0d, expected none", done, y0);
                end else begin
                    e = exp_q.pop_front();
                    if ({done, y0} !== e) begin
                        errors++;
                        $display("FAIL y0_stream: got done=%0d y0=%0d, expected done=%0d y0=%0d",
                                 done, y0, e[11], e[10:0]);
                    end else
                        $display("[TB] frame y0=%0d done=%0d", y0, done);
                end
                prev_y0 = y0;
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset held low while the frame counter runs, including the tick coordinate.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            x = (i % 3 == 0) ? 11'd0 : 11'(i * 37);
            y = (i % 2 == 0) ? 11'(TICK_Y) : 11'(i);
            #1 check("reset_outputs", {19'd0, y0, spinning, done}, 32'd0);
        end
        x = 11'd7; y = 11'd100;
        @(negedge clk); reset = 1'b1;
        bus_read("reset_status", 2'd0, 32'd0);
        bus_read("reset_speed_reg", 2'd2, 32'd8);
`ifdef REEL_AUTOSTOP_EN
        bus_read("reset_cruise_frames", 2'd3, 32'd60);
`else
        bus_read("reset_cruise_frames", 2'd3, 32'd0);
`endif

        // Full spin: max 4, target 2, stop during ACCEL.
        bus_write(2'd2, 32'd4);
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'd1);
        bus_read("state_accel", 2'd0, 32'd1);
        tick_expect(1, 1'b0);
        bus_write(2'd0, 32'd2);
        tick_expect(2, 1'b0);
        tick_expect(3, 1'b0);
        bus_read("state_cruise", 2'd0, 32'd2);
        tick_expect(4, 1'b0);
        bus_read("state_decel", 2'd0, 32'd3);
        tick_expect(4, 1'b0);
        tick_expect(3, 1'b0);
        tick_expect(2, 1'b0);
        bus_read("state_seek", 2'd0, 32'd4);
        for (int i = 0; i < 44; i++) tick_expect(1, 1'b0);
        tick_expect(1, 1'b1);
        bus_read("settled_status", 2'd0, 32'd8);
        bus_read("settled_pos", 2'd1, 32'd64);
        bus_read("settled_speed", 2'd2, 32'd4);

        // Start written in the same cycle as a tick: no motion on that tick.
        @(negedge clk);
        x = 11'd0; y = 11'(TICK_Y); cs = 1'b1; write = 1'b1; addr = 2'd0; wr_data = 32'd1;
        @(negedge clk);
        x = 11'd7; y = 11'd100; cs = 1'b0; write = 1'b0;
        bus_read("start_tick_pos", 2'd1, 32'd64);
        bus_read("start_tick_state", 2'd0, 32'd1);
        tick_expect(1, 1'b0);
        bus_read("next_tick_pos", 2'd1, 32'd65);
        bus_write(2'd0, 32'd2);
        tick_expect(2, 1'b0);
        tick_expect(3, 1'b0);
        tick_expect(4, 1'b0);
        tick_expect(4, 1'b0);
        tick_expect(3, 1'b0);
        tick_expect(2, 1'b0);
        bus_write(2'd1, 32'd5);
        for (int i = 0; i < 76; i++) tick_expect(1, 1'b0);
        tick_expect(1, 1'b1);
        bus_read("seek5_pos", 2'd1, 32'd160);

        // max_speed clamping, ignored start in CRUISE, strip wrap, then reset mid-spin.
        bus_write(2'd2, 32'd0);
        bus_read("max_clamp_low", 2'd2, 32'd1);
        bus_write(2'd2, 32'd50);
        bus_read("max_clamp_high", 2'd2, 32'd32);
        bus_write(2'd2, 32'd9);
        bus_write(2'd0, 32'd1);
        for (int s = 1; s <= 8; s++) tick_expect(s, 1'b0);
        bus_read("cruise9_state", 2'd0, 32'd2);
        bus_write(2'd0, 32'd1);
        bus_read("start_in_cruise_state", 2'd0, 32'd2);
        bus_read("start_in_cruise_speed", 2'd2, 32'd585);
        for (int i = 0; i < 4; i++) tick_expect(9, 1'b0);
        bus_write(2'd0, 32'd2);
        tick_expect(9, 1'b0);
        bus_read("decel_state", 2'd0, 32'd3);
        tick_expect(9, 1'b0);
        bus_read("prewrap_pos", 2'd1, 32'd250);
        bus_read("prewrap_speed", 2'd2, 32'd521);
        tick_expect(8, 1'b0);
        bus_read("wrap_pos", 2'd1, 32'd2);
        tick_expect(7, 1'b0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("midspin_reset_outputs", {19'd0, y0, spinning, done}, 32'd0);
        end
        @(negedge clk); reset = 1'b1;
        exp_pos = 0;
        bus_read("post_reset_status", 2'd0, 32'd0);
        bus_read("post_reset_pos", 2'd1, 32'd0);
        bus_read("post_reset_speed", 2'd2, 32'd8);

        // Automatic stop after cruise_frames CRUISE ticks (or none without the feature).
        bus_write(2'd3, 32'd3);
`ifdef REEL_AUTOSTOP_EN
        bus_read("cruise_frames_wr", 2'd3, 32'd3);
`else
        bus_read("cruise_frames_wr", 2'd3, 32'd0);
`endif
        bus_write(2'd0, 32'd1);
        for (int s = 1; s <= 7; s++) tick_expect(s, 1'b0);
        bus_read("auto_cruise_state", 2'd0, 32'd2);
`ifdef REEL_AUTOSTOP_EN
        tick_expect(8, 1'b0);
        bus_read("auto_tick1_state", 2'd0, 32'd2);
        tick_expect(8, 1'b0);
        bus_read("auto_tick2_state", 2'd0, 32'd2);
        tick_expect(8, 1'b0);
        bus_read("auto_tick3_state", 2'd0, 32'd3);
`else
        for (int i = 0; i < 300; i++) tick_expect(8, 1'b0);
        bus_read("no_autostop_state", 2'd0, 32'd2);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
